regfile_write_arbiter: RTL and testbench

//   Shares the register bank's single write port between two writeback sources:
//   ALU results and memory/load results. Each source gets a small FIFO, and a

---
 rtl/regarb_pkg.sv | 12 +
 rtl/regfile_write_arbiter_if.sv | 27 ++
 rtl/regarb_fifo.sv | 54 +++++
 rtl/regfile_write_arbiter.sv | 89 ++++++++
 tb/tb_regfile_write_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/regarb_pkg.sv
// regarb_pkg: shared types and default widths for the register-bank write arbiter.
package regarb_pkg;
    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 5;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wr_req_t;

    typedef enum logic {SRC_ALU, SRC_MEM} src_e;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: writeback request, bank write and hazard-query signals.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = regarb_pkg::DATA_W_DEF,
    parameter int ADDR_W = regarb_pkg::ADDR_W_DEF
);
    logic              alu_valid, alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid, mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              rf_write;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] rd_addr_1, rd_addr_2;
    logic              raw_hazard_1, raw_hazard_2;
    logic              idle;

    modport master (
        output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, rd_addr_1, rd_addr_2,
        input  alu_ready, mem_ready, rf_write, rf_waddr, rf_wdata, raw_hazard_1, raw_hazard_2, idle
    );
    modport slave (
        input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, rd_addr_1, rd_addr_2,
        output alu_ready, mem_ready, rf_write, rf_waddr, rf_wdata, raw_hazard_1, raw_hazard_2, idle
    );
endinterface

// File: rtl/regarb_fifo.sv
// regarb_fifo: small sync FIFO of write requests; exposes per-entry valid/addr for hazard compares.
module regarb_fifo
    import regarb_pkg::*;
#(
    parameter type req_t  = wr_req_t,
    parameter int  ADDR_W = ADDR_W_DEF,
    parameter int  DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  req_t                         din_i,
    output logic                         full_o,
    output logic                         empty_o,
    output req_t                         head_o,
    output logic [DEPTH-1:0]             ent_vld_o,
    output logic [DEPTH-1:0][ADDR_W-1:0] ent_addr_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    req_t          mem_q [DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wp_q <= wp_q + PW'(1);
            if (pop_i) rp_q <= rp_q + PW'(1);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wp_q] <= din_i;
    end

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign head_o  = mem_q[rp_q];

    // An entry is live when its distance from the read pointer is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PW-1:0] off;
        assign off           = PW'(i) - rp_q;
        assign ent_vld_o[i]  = {1'b0, off} < cnt_q;
        assign ent_addr_o[i] = mem_q[i].addr;
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin merge of ALU and load writebacks onto one bank write port.
// REGARB_ZERO_REG_EN: drop writes to r0 and never flag hazards on r0.
module regfile_write_arbiter
    import regarb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    regfile_write_arbiter_if.slave bus
);
`ifdef REGARB_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t                              a_head, m_head;
    logic                              a_full, a_empty, m_full, m_empty;
    logic [FIFO_DEPTH-1:0]             a_vld, m_vld;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0] a_addr, m_addr;
    logic                              a_push, m_push, grant_a, grant_m, hz_1, hz_2;
    src_e                              last_q, last_d;
    logic                              rf_write_q, rf_write_d;
    logic [ADDR_W-1:0]                 rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]                 rf_wdata_q, rf_wdata_d;

    assign bus.alu_ready = rst_n && !a_full;
    assign bus.mem_ready = rst_n && !m_full;
    assign a_push = bus.alu_valid && bus.alu_ready && !(ZERO_EN && bus.alu_addr == '0);
    assign m_push = bus.mem_valid && bus.mem_ready && !(ZERO_EN && bus.mem_addr == '0);

    regarb_fifo #(.req_t(req_t), .ADDR_W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk, .rst_n, .push_i(a_push), .pop_i(grant_a), .din_i(req_t'({bus.alu_addr, bus.alu_data})),
        .full_o(a_full), .empty_o(a_empty), .head_o(a_head), .ent_vld_o(a_vld), .ent_addr_o(a_addr)
    );

    regarb_fifo #(.req_t(req_t), .ADDR_W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk, .rst_n, .push_i(m_push), .pop_i(grant_m), .din_i(req_t'({bus.mem_addr, bus.mem_data})),
        .full_o(m_full), .empty_o(m_empty), .head_o(m_head), .ent_vld_o(m_vld), .ent_addr_o(m_addr)
    );

    always_comb begin
        grant_a    = !a_empty && (m_empty || last_q == SRC_MEM);
        grant_m    = !m_empty && !grant_a;
        last_d     = grant_a ? SRC_ALU : grant_m ? SRC_MEM : last_q;
        rf_write_d = grant_a || grant_m;
        rf_waddr_d = grant_a ? a_head.addr : grant_m ? m_head.addr : rf_waddr_q;
        rf_wdata_d = grant_a ? a_head.data : grant_m ? m_head.data : rf_wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= SRC_MEM;
            rf_write_q <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            last_q     <= last_d;
            rf_write_q <= rf_write_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // A write is pending while queued in either FIFO or on the bank port this cycle.
    always_comb begin
        hz_1 = rf_write_q && rf_waddr_q == bus.rd_addr_1;
        hz_2 = rf_write_q && rf_waddr_q == bus.rd_addr_2;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            hz_1 = hz_1 || (a_vld[k] && a_addr[k] == bus.rd_addr_1) || (m_vld[k] && m_addr[k] == bus.rd_addr_1);
            hz_2 = hz_2 || (a_vld[k] && a_addr[k] == bus.rd_addr_2) || (m_vld[k] && m_addr[k] == bus.rd_addr_2);
        end
    end

    assign bus.raw_hazard_1 = hz_1 && !(ZERO_EN && bus.rd_addr_1 == '0);
    assign bus.raw_hazard_2 = hz_2 && !(ZERO_EN && bus.rd_addr_2 == '0);
    assign bus.rf_write     = rf_write_q;
    assign bus.rf_waddr     = rf_waddr_q;
    assign bus.rf_wdata     = rf_wdata_q;
    assign bus.idle         = a_empty && m_empty && !rf_write_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of arbitration, backpressure, hazards and reset.
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter_if bus ();
    regfile_write_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.alu_valid = 0; bus.alu_addr = '0; bus.alu_data = '0;
        bus.mem_valid = 0; bus.mem_addr = '0; bus.mem_data = '0;
        bus.rd_addr_1 = 5'd31; bus.rd_addr_2 = 5'd31;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] a, input logic [63:0] d);
        bus.alu_valid = v; bus.alu_addr = a; bus.alu_data = d;
    endtask

    task automatic drive_mem(input logic v, input logic [4:0] a, input logic [63:0] d);
        bus.mem_valid = v; bus.mem_addr = a; bus.mem_data = d;
    endtask

    int a_it [11] = '{0, 1, 2, 3, 3, -1, -1, -1, -1, -1, -1};
    int m_it [11] = '{0, 1, 2, 2, 3, 3, -1, -1, -1, -1, -1};
    int a_rdy [6] = '{1, 1, 1, 0, 1, 0};
    int m_rdy [6] = '{1, 1, 0, 1, 0, 1};
    int wr_code [11] = '{-1, -1, 0, 4, 1, 5, 2, 6, 3, 7, -1};

    initial begin
        clear_inputs();
        #1 rst_n = 0;
        #2;
        check("rst_alu_ready", bus.alu_ready, 0);
        check("rst_mem_ready", bus.mem_ready, 0);
        check("rst_rf_write", bus.rf_write, 0);
        check("rst_waddr", bus.rf_waddr, 0);
        check("rst_wdata", bus.rf_wdata, 0);
        check("rst_idle", bus.idle, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        #2 check("post_rst_alu_ready", bus.alu_ready, 1);

        // single uncontested ALU write
        step();
        drive_alu(1, 5'd3, 64'hA5);
        #2 check("t1_idle_pre", bus.idle, 1);
        step();
        drive_alu(0, 0, 0);
        #2 check("t1_e0_write", bus.rf_write, 0);
        check("t1_e0_idle", bus.idle, 0);
        step();
        #2 check("t1_write", bus.rf_write, 1);
        check("t1_waddr", bus.rf_waddr, 3);
        check("t1_wdata", bus.rf_wdata, 64'hA5);
        check("t1_idle_busy", bus.idle, 0);
        step();
        #2 check("t1_write_done", bus.rf_write, 0);
        check("t1_idle_back", bus.idle, 1);

        // first contested grant after reset goes to ALU
        do_reset();
        drive_alu(1, 5'd1, 64'h11);
        drive_mem(1, 5'd2, 64'h22);
        step();
        drive_alu(0, 0, 0);
        drive_mem(0, 0, 0);
        #2 check("t2_e0_write", bus.rf_write, 0);
        step();
        #2 check("t2_w1", bus.rf_write, 1);
        check("t2_w1_addr", bus.rf_waddr, 1);
        check("t2_w1_data", bus.rf_wdata, 64'h11);
        step();
        #2 check("t2_w2", bus.rf_write, 1);
        check("t2_w2_addr", bus.rf_waddr, 2);
        check("t2_w2_data", bus.rf_wdata, 64'h22);
        step();
        #2 check("t2_done", bus.rf_write, 0);
        check("t2_idle", bus.idle, 1);

        // backpressure under contention: ready drops at full, reopens after a pop
        do_reset();
        for (int c = 0; c < 11; c++) begin
            if (a_it[c] >= 0) drive_alu(1, 5'(10 + a_it[c]), 64'hA000 + 64'(a_it[c]));
            else drive_alu(0, 0, 0);
            if (m_it[c] >= 0) drive_mem(1, 5'(20 + m_it[c]), 64'hB000 + 64'(m_it[c]));
            else drive_mem(0, 0, 0);
            #2;
            if (c < 6) begin
                check($sformatf("t3_alu_ready_c%0d", c), bus.alu_ready, 64'(a_rdy[c]));
                check($sformatf("t3_mem_ready_c%0d", c), bus.mem_ready, 64'(m_rdy[c]));
            end
            if (wr_code[c] < 0) check($sformatf("t3_nowrite_c%0d", c), bus.rf_write, 0);
            else begin
                check($sformatf("t3_write_c%0d", c), bus.rf_write, 1);
                check($sformatf("t3_waddr_c%0d", c), bus.rf_waddr,
                      wr_code[c] < 4 ? 64'(10 + wr_code[c]) : 64'(16 + wr_code[c]));
                check($sformatf("t3_wdata_c%0d", c), bus.rf_wdata,
                      wr_code[c] < 4 ? 64'hA000 + 64'(wr_code[c]) : 64'hB000 + 64'(wr_code[c] - 4));
            end
            step();
        end
        #2 check("t3_idle", bus.idle, 1);

        // RAW hazard tracks a pending load through its bank write
        do_reset();
        bus.rd_addr_1 = 5'd7;
        bus.rd_addr_2 = 5'd8;
        drive_mem(1, 5'd7, 64'h77);
        #2 check("t4_hz1_before", bus.raw_hazard_1, 0);
        step();
        drive_mem(0, 0, 0);
        #2 check("t4_hz1_queued", bus.raw_hazard_1, 1);
        check("t4_hz2_queued", bus.raw_hazard_2, 0);
        step();
        #2 check("t4_write", bus.rf_write, 1);
        check("t4_hz1_writing", bus.raw_hazard_1, 1);
        step();
        #2 check("t4_hz1_after", bus.raw_hazard_1, 0);

        // mid-cycle reset discards pending writes
        do_reset();
        drive_alu(1, 5'd4, 64'h44);
        drive_mem(1, 5'd5, 64'h55);
        bus.rd_addr_1 = 5'd5;
        step();
        drive_alu(0, 0, 0);
        drive_mem(0, 0, 0);
        step();
        #2 check("t5_write_pre", bus.rf_write, 1);
        check("t5_hz_pre", bus.raw_hazard_1, 1);
        rst_n = 0;
        #1 check("t5_write_rst", bus.rf_write, 0);
        check("t5_idle_rst", bus.idle, 1);
        check("t5_hz_rst", bus.raw_hazard_1, 0);
        check("t5_ready_rst", bus.alu_ready, 0);
        @(posedge clk);
        #1 rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            #2 check($sformatf("t5_nowrite_%0d", c), bus.rf_write, 0);
            step();
        end
        #2 check("t5_idle_after", bus.idle, 1);

        // write to r0
        do_reset();
        bus.rd_addr_1 = 5'd0;
        drive_alu(1, 5'd0, 64'h5A);
        #2 check("t6_ready", bus.alu_ready, 1);
        step();
        drive_alu(0, 0, 0);
`ifdef REGARB_ZERO_REG_EN
        #2 check("t6_hz_r0", bus.raw_hazard_1, 0);
        check("t6_idle_dropped", bus.idle, 1);
        step();
        #2 check("t6_nowrite", bus.rf_write, 0);
`else
        #2 check("t6_hz_r0", bus.raw_hazard_1, 1);
        step();
        #2 check("t6_write", bus.rf_write, 1);
        check("t6_waddr", bus.rf_waddr, 0);
        check("t6_wdata", bus.rf_wdata, 64'h5A);
`endif
        step();
        #2 check("t6_idle", bus.idle, 1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
